// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - register file write/read port bundle
interface register_file_if #(
    parameter int N_BITS = 32,
    parameter int ADDR_W = 5
);
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [N_BITS-1:0] WriteData;
    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic [N_BITS-1:0] ReadData1;
    logic [N_BITS-1:0] ReadData2;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 32 x 32 MIPS GPR file, two combinational reads, one write
module register_file #(
    parameter int              N_BITS       = 32,
    parameter int              ADDR_W       = 5,
    parameter logic [N_BITS-1:0] GP_INIT    = 32'h1000_8000,
    parameter logic [N_BITS-1:0] SP_INIT    = 32'h7FFF_EFFC,
    parameter int              WRITE_BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    register_file_if.slave       rf
);
    localparam int N_REGS = 2 ** ADDR_W;
    localparam bit BYPASS = (WRITE_BYPASS != 0);

    // $zero has no storage; index 0 is never read or written
    logic [N_BITS-1:0] regs [1:N_REGS-1];

    logic fwd1;
    logic fwd2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 1; i < N_REGS; i++) begin
                if (i == 28)
                    regs[i] <= GP_INIT;
                else if (i == 29)
                    regs[i] <= SP_INIT;
                else
                    regs[i] <= '0;
            end
        end else if (rf.RegWrite && (rf.WriteRegister != '0)) begin
            regs[rf.WriteRegister] <= rf.WriteData;
        end
    end

    // Forwarding is suppressed during reset so the reset values are what the ALU sees
    assign fwd1 = BYPASS && reset && rf.RegWrite && (rf.WriteRegister == rf.ReadRegister1);
    assign fwd2 = BYPASS && reset && rf.RegWrite && (rf.WriteRegister == rf.ReadRegister2);

    always_comb begin
        rf.ReadData1 = '0;
        if (rf.ReadRegister1 != '0) begin
            if (fwd1)
                rf.ReadData1 = rf.WriteData;
            else
                rf.ReadData1 = regs[rf.ReadRegister1];
        end
    end

    always_comb begin
        rf.ReadData2 = '0;
        if (rf.ReadRegister2 != '0) begin
            if (fwd2)
                rf.ReadData2 = rf.WriteData;
            else
                rf.ReadData2 = regs[rf.ReadRegister2];
        end
    end
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;
    localparam logic [31:0] GP = 32'h1000_8000;
    localparam logic [31:0] SP = 32'h7FFF_EFFC;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    register_file_if #(.N_BITS(32), .ADDR_W(5)) rf ();
    register_file_if #(.N_BITS(32), .ADDR_W(5)) rf_nb ();

    register_file #(.WRITE_BYPASS(1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf)
    );

    register_file #(.WRITE_BYPASS(0)) u_dut_nb (
        .clk   (clk),
        .reset (reset),
        .rf    (rf_nb)
    );

    // The non-bypass copy sees identical stimulus
    assign rf_nb.RegWrite      = rf.RegWrite;
    assign rf_nb.WriteRegister = rf.WriteRegister;
    assign rf_nb.WriteData     = rf.WriteData;
    assign rf_nb.ReadRegister1 = rf.ReadRegister1;
    assign rf_nb.ReadRegister2 = rf.ReadRegister2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        rf.RegWrite      = 1'b1;
        rf.WriteRegister = a;
        rf.WriteData     = d;
        @(posedge clk);
        #1;
        rf.RegWrite = 1'b0;
    endtask

    task automatic set_read(input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        rf.ReadRegister1 = a;
        rf.ReadRegister2 = b;
        #1;
    endtask

    task automatic test_reset;
        logic [4:0]  addrs [4];
        logic [31:0] exps  [4];
        addrs = '{5'd0, 5'd28, 5'd29, 5'd8};
        exps  = '{32'h0, GP, SP, 32'h0};
        @(negedge clk);
        reset            = 1'b0;
        rf.RegWrite      = 1'b1;
        rf.WriteRegister = 5'd28;
        rf.WriteData     = 32'h0000_0005;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            rf.ReadRegister1 = addrs[k];
            rf.ReadRegister2 = addrs[k];
            #1;
            n_checks++;
            if (rf.ReadData1 !== exps[k]) begin
                n_fail++;
                $display("FAIL reset_rd1 r%0d: got %h expected %h", addrs[k], rf.ReadData1, exps[k]);
            end
            n_checks++;
            if (rf.ReadData2 !== exps[k]) begin
                n_fail++;
                $display("FAIL reset_rd2 r%0d: got %h expected %h", addrs[k], rf.ReadData2, exps[k]);
            end
            n_checks++;
            if (rf_nb.ReadData1 !== exps[k]) begin
                n_fail++;
                $display("FAIL reset_nb_rd1 r%0d: got %h expected %h", addrs[k], rf_nb.ReadData1, exps[k]);
            end
        end
        @(negedge clk);
        reset       = 1'b1;
        rf.RegWrite = 1'b0;
    endtask

    task automatic test_write;
        do_write(5'd8, 32'hDEAD_BEEF);
        set_read(5'd8, 5'd8);
        n_checks++;
        if (rf.ReadData1 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL write_rd1 r8: got %h expected %h", rf.ReadData1, 32'hDEAD_BEEF);
        end
        n_checks++;
        if (rf.ReadData2 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL write_rd2 r8: got %h expected %h", rf.ReadData2, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_zero;
        @(negedge clk);
        rf.RegWrite      = 1'b1;
        rf.WriteRegister = 5'd0;
        rf.WriteData     = 32'hFFFF_FFFF;
        rf.ReadRegister1 = 5'd0;
        rf.ReadRegister2 = 5'd8;
        #1;
        n_checks++;
        if (rf.ReadData1 !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_fwd r0: got %h expected %h", rf.ReadData1, 32'h0);
        end
        @(posedge clk);
        #1;
        rf.RegWrite = 1'b0;
        set_read(5'd0, 5'd8);
        n_checks++;
        if (rf.ReadData1 !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_read r0: got %h expected %h", rf.ReadData1, 32'h0);
        end
        n_checks++;
        if (rf.ReadData2 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL zero_other r8: got %h expected %h", rf.ReadData2, 32'hDEAD_BEEF);
        end
        set_read(5'd28, 5'd29);
        n_checks++;
        if (rf.ReadData1 !== GP) begin
            n_fail++;
            $display("FAIL zero_other r28: got %h expected %h", rf.ReadData1, GP);
        end
        n_checks++;
        if (rf.ReadData2 !== SP) begin
            n_fail++;
            $display("FAIL zero_other r29: got %h expected %h", rf.ReadData2, SP);
        end
    endtask

    task automatic test_bypass;
        @(negedge clk);
        rf.RegWrite      = 1'b1;
        rf.WriteRegister = 5'd9;
        rf.WriteData     = 32'h1234_5678;
        rf.ReadRegister1 = 5'd9;
        rf.ReadRegister2 = 5'd9;
        #1;
        n_checks++;
        if (rf.ReadData1 !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL bypass_fwd rd1: got %h expected %h", rf.ReadData1, 32'h1234_5678);
        end
        n_checks++;
        if (rf.ReadData2 !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL bypass_fwd rd2: got %h expected %h", rf.ReadData2, 32'h1234_5678);
        end
        n_checks++;
        if (rf_nb.ReadData1 !== 32'h0) begin
            n_fail++;
            $display("FAIL nobypass_old rd1: got %h expected %h", rf_nb.ReadData1, 32'h0);
        end
        @(posedge clk);
        #1;
        rf.RegWrite = 1'b0;
        #1;
        n_checks++;
        if (rf_nb.ReadData1 !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL nobypass_after rd1: got %h expected %h", rf_nb.ReadData1, 32'h1234_5678);
        end
        n_checks++;
        if (rf.ReadData1 !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL bypass_after rd1: got %h expected %h", rf.ReadData1, 32'h1234_5678);
        end
    endtask

    task automatic test_reset_mid;
        do_write(5'd29, 32'h0000_0100);
        set_read(5'd29, 5'd29);
        n_checks++;
        if (rf.ReadData1 !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL midreset_pre r29: got %h expected %h", rf.ReadData1, 32'h0000_0100);
        end
        @(negedge clk);
        reset            = 1'b0;
        rf.RegWrite      = 1'b1;
        rf.WriteRegister = 5'd5;
        rf.WriteData     = 32'h0000_0007;
        rf.ReadRegister1 = 5'd5;
        #1;
        n_checks++;
        if (rf.ReadData1 !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_nofwd r5: got %h expected %h", rf.ReadData1, 32'h0);
        end
        @(posedge clk);
        #1;
        reset       = 1'b1;
        rf.RegWrite = 1'b0;
        set_read(5'd29, 5'd5);
        n_checks++;
        if (rf.ReadData1 !== SP) begin
            n_fail++;
            $display("FAIL midreset r29: got %h expected %h", rf.ReadData1, SP);
        end
        n_checks++;
        if (rf.ReadData2 !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset r5: got %h expected %h", rf.ReadData2, 32'h0);
        end
        set_read(5'd8, 5'd9);
        n_checks++;
        if (rf.ReadData1 !== 32'h0 || rf.ReadData2 !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_clear r8/r9: got %h/%h expected 0/0", rf.ReadData1, rf.ReadData2);
        end
    endtask

    task automatic test_walk;
        logic [31:0] model [32];
        logic [31:0] e1;
        logic [31:0] e2;
        logic [4:0]  a;
        logic [4:0]  b;
        model[0] = 32'h0;
        for (int i = 1; i < 32; i++) begin
            a        = 5'(i);
            model[i] = 32'(i) * 32'h0101_0101;
            do_write(a, model[i]);
        end
        @(negedge clk);
        rf.RegWrite      = 1'b0;
        rf.WriteRegister = 5'd7;
        rf.WriteData     = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 32; i++) begin
            a  = 5'(i);
            b  = 5'(31 - i);
            e1 = model[i];
            e2 = model[31 - i];
            set_read(a, b);
            n_checks++;
            if (rf.ReadData1 !== e1 || rf.ReadData2 !== e2) begin
                n_fail++;
                $display("FAIL walk r%0d/r%0d: got %h/%h expected %h/%h", a, b, rf.ReadData1, rf.ReadData2, e1, e2);
            end
            n_checks++;
            if (rf_nb.ReadData1 !== e1 || rf_nb.ReadData2 !== e2) begin
                n_fail++;
                $display("FAIL walk_nb r%0d/r%0d: got %h/%h expected %h/%h", a, b, rf_nb.ReadData1, rf_nb.ReadData2, e1, e2);
            end
        end
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        reset            = 1'b1;
        rf.RegWrite      = 1'b0;
        rf.WriteRegister = '0;
        rf.WriteData     = '0;
        rf.ReadRegister1 = '0;
        rf.ReadRegister2 = '0;
        test_reset();
        test_write();
        test_zero();
        test_bypass();
        test_reset_mid();
        test_walk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
